// File: rtl/mem_host_port.sv
// mem_host_port: owns Mem4K port A; loads a program with the core held in reset, runs it, then dumps memory.
// Optional feature macro DUMP_SKIPZERO_EN: zero dump words are skipped (the final word is always presented).
module mem_host_port #(
  parameter int unsigned LOAD_BASE = 2048,
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        core_rst,
  input  logic [31:0] core_iaddr,
  output logic [31:0] core_instr,
  output logic        mem_enwr,
  output logic [31:0] mem_abus,
  output logic [31:0] mem_dbusw,
  input  logic [31:0] mem_dbusr,
  output logic        dump_valid,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_nz,
  output logic        dump_last,
  input  logic        dump_ready,
  output logic        timed_out,
  output logic        done
);

  localparam logic        MM_ENB_W  = 1'b1;
  localparam logic        MM_ENB_R  = 1'b0;
  localparam logic [31:0] BASE_ADDR = 32'(LOAD_BASE);
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);
  localparam logic [31:0] RUN_LIMIT = 32'(TIMEOUT);

  typedef enum logic [2:0] {S_LOAD, S_RUN, S_DRD, S_DOUT, S_DONE} state_t;

  state_t      state;
  logic [31:0] waddr;
  logic [31:0] raddr;
  logic [31:0] cnt;
  logic [31:0] cnt_inc;
  logic        rd_wait;
  logic        ld_fire;
  logic        run_halt;
  logic        present;

  assign ld_fire    = (state == S_LOAD) && ld_valid && ld_ready;
  assign cnt_inc    = cnt + 32'd1;
  assign run_halt   = (core_iaddr == '0) || (cnt_inc > RUN_LIMIT);
  assign core_instr = mem_dbusr;
  assign dump_addr  = raddr;

`ifdef DUMP_SKIPZERO_EN
  assign present = (mem_dbusr != '0) || (raddr == LAST_ADDR);
`else
  assign present = 1'b1;
`endif

  always_comb begin
    mem_enwr  = MM_ENB_R;
    mem_abus  = raddr;
    mem_dbusw = '0;
    unique case (state)
      S_LOAD: begin
        mem_abus  = waddr;
        mem_dbusw = ld_data;
        if (ld_fire) mem_enwr = MM_ENB_W;
      end
      S_RUN:   mem_abus = core_iaddr;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      waddr      <= BASE_ADDR;
      raddr      <= '0;
      cnt        <= '0;
      rd_wait    <= 1'b0;
      core_rst   <= 1'b1;
      ld_ready   <= 1'b1;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_nz    <= 1'b0;
      dump_last  <= 1'b0;
      timed_out  <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (ld_fire) begin
            waddr <= waddr + 32'd4;
            if (ld_last || waddr == LAST_ADDR) begin
              state    <= S_RUN;
              ld_ready <= 1'b0;
              core_rst <= 1'b0;
              cnt      <= '0;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt_inc;
          if (run_halt) begin
            state     <= S_DRD;
            core_rst  <= 1'b1;
            raddr     <= '0;
            rd_wait   <= 1'b0;
            timed_out <= (core_iaddr != '0);
          end
        end
        S_DRD: begin
          // Address is held for RD_LAT extra cycles so a registered-read memory has data on the capture edge.
          if (RD_LAT == 0 || rd_wait) begin
            rd_wait    <= 1'b0;
            dump_data  <= mem_dbusr;
            dump_nz    <= (mem_dbusr != '0);
            dump_last  <= (raddr == LAST_ADDR);
            dump_valid <= present;
            state      <= S_DOUT;
          end else begin
            rd_wait <= 1'b1;
          end
        end
        S_DOUT: begin
          if (!dump_valid || dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            if (raddr == LAST_ADDR) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              raddr <= raddr + 32'd4;
              state <= S_DRD;
            end
          end
        end
        S_DONE: ;
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_host_port.sv
// Bench for mem_host_port: behavioural Mem4K stand-in plus an image/sequence reference model.
module tb_mem_host_port;

  localparam int unsigned LOAD_BASE = 2048;
  localparam int unsigned MEM_BYTES = 4096;
  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned WORDS     = MEM_BYTES / 4;
  localparam logic        ENB_W     = 1'b1;
  localparam logic        ENB_R     = 1'b0;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        core_rst;
  logic [31:0] core_iaddr;
  logic [31:0] core_instr;
  logic        mem_enwr;
  logic [31:0] mem_abus;
  logic [31:0] mem_dbusw;
  logic [31:0] mem_dbusr;
  logic        dump_valid;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;
  logic        dump_nz;
  logic        dump_last;
  logic        dump_ready;
  logic        timed_out;
  logic        done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] mem     [WORDS] = '{default: '0};
  logic [31:0] ref_mem [WORDS] = '{default: '0};
  logic [31:0] ld_q [$];

  mem_host_port #(
    .LOAD_BASE(LOAD_BASE),
    .MEM_BYTES(MEM_BYTES),
    .TIMEOUT  (TIMEOUT),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .core_rst  (core_rst),
    .core_iaddr(core_iaddr),
    .core_instr(core_instr),
    .mem_enwr  (mem_enwr),
    .mem_abus  (mem_abus),
    .mem_dbusw (mem_dbusw),
    .mem_dbusr (mem_dbusr),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_nz   (dump_nz),
    .dump_last (dump_last),
    .dump_ready(dump_ready),
    .timed_out (timed_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mem4K port A stand-in: write on the edge, one-cycle registered read.
  always @(posedge clk) begin
    if (mem_enwr == ENB_W) mem[mem_abus[11:2]] <= mem_dbusw;
    mem_dbusr <= mem[mem_abus[11:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned next_exp(input int unsigned i);
    int unsigned j = i;
`ifdef DUMP_SKIPZERO_EN
    while (j < WORDS - 1 && ref_mem[j] == '0) j++;
`endif
    return j;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; dump_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ld_ready"}, ld_ready, 1);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_dump_valid"}, dump_valid, 0);
    check({tag, "_dump_last"}, dump_last, 0);
    check({tag, "_timed_out"}, timed_out, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_enwr"}, mem_enwr, ENB_R);
    check({tag, "_waddr"}, mem_abus, LOAD_BASE);
  endtask

  task automatic load_queue(input bit use_last, input bit gaps);
    int unsigned exp_addr = LOAD_BASE;
    int unsigned i = 0;
    int unsigned cyc = 0;
    while (i < ld_q.size() && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        check("load_idle_enwr", mem_enwr, ENB_R);
        continue;
      end
      ld_valid = 1'b1;
      ld_data  = ld_q[i];
      ld_last  = use_last && (i == ld_q.size() - 1);
      #1;
      check("load_ready", ld_ready, 1);
      check("load_enwr", mem_enwr, ENB_W);
      check("load_abus", mem_abus, exp_addr);
      check("load_dbusw", mem_dbusw, ld_q[i]);
      check("load_core_rst", core_rst, 1);
      ref_mem[exp_addr / 4] = ld_q[i];
      exp_addr += 4;
      i++;
    end
    check("load_complete", i, ld_q.size());
  endtask

  // PC walks the loaded region; zero_at (1-based RUN cycle, 0 = never) forces a zero PC.
  task automatic run_core(input int unsigned zero_at, input bit keep_ld);
    int unsigned n = 0;
    int unsigned exp_n;
    int unsigned last_pc = 0;
    bit exp_to;
    bit ended = 1'b0;
    exp_n  = (zero_at != 0 && zero_at <= TIMEOUT + 1) ? zero_at : TIMEOUT + 1;
    exp_to = (zero_at != exp_n);
    while (n < 200) begin
      @(negedge clk);
      if (n == 0) begin
        ld_valid = keep_ld; ld_last = 1'b0; ld_data = $urandom;
      end
      n++;
      core_iaddr = (n == zero_at) ? 32'h0 : 32'(LOAD_BASE + 4 * ((n - 1) % 3));
      #1;
      if (core_rst) begin
        ended = 1'b1;
        break;
      end
      check("run_abus", mem_abus, core_iaddr);
      check("run_enwr", mem_enwr, ENB_R);
      check("run_dbusw", mem_dbusw, 0);
      check("run_ld_ready", ld_ready, 0);
      if (n > 1) check("run_instr", core_instr, ref_mem[last_pc / 4]);
      last_pc = core_iaddr;
    end
    check("run_ended", ended, 1);
    check("run_cycles", n - 1, exp_n);
    check("run_timed_out", timed_out, exp_to);
    check("run_exit_abus", mem_abus, 0);
    check("run_exit_valid", dump_valid, 0);
  endtask

  // stop_after >= 0: return while that many words have been accepted and the next is on offer.
  task automatic dump_all(input bit rand_ready, input int stop_after);
    int unsigned idx;
    int unsigned acc = 0;
    int unsigned cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] sa = '0;
    logic [31:0] sd = '0;
    idx = next_exp(0);
    while (cyc < 20000) begin
      @(negedge clk);
      #1;
      cyc++;
      if (done) break;
      if (stalled) begin
        check("stall_valid", dump_valid, 1);
        check("stall_addr", dump_addr, sa);
        check("stall_data", dump_data, sd);
      end
      if (dump_valid) begin
        check("dump_addr", dump_addr, idx * 4);
        check("dump_data", dump_data, ref_mem[idx]);
        check("dump_nz", dump_nz, ref_mem[idx] != '0);
        check("dump_last", dump_last, idx == WORDS - 1);
        check("dump_core_rst", core_rst, 1);
        check("dump_dbusw", mem_dbusw, 0);
        if (stop_after >= 0 && int'(acc) == stop_after) begin
          dump_ready = 1'b0;
          return;
        end
        dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dump_ready) begin
          acc++;
          idx = next_exp(idx + 1);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          sa = dump_addr;
          sd = dump_data;
        end
      end else begin
        stalled = 1'b0;
        dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    check("dump_done", done, 1);
    check("dump_count", idx, WORDS);
    check("done_valid", dump_valid, 0);
    check("done_core_rst", core_rst, 1);
  endtask

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    core_iaddr = 32'(LOAD_BASE); dump_ready = 1'b0;

    do_reset();
    check_reset("rst0");

    // Directed three-word program, zero-PC halt, full dump without back-pressure.
    ld_q = '{32'h00000013, 32'h00100093, 32'h00000067};
    load_queue(1'b1, 1'b0);
    run_core(3, 1'b0);
    dump_all(1'b0, -1);
    repeat (3) @(negedge clk);
    #1;
    check("done_held", done, 1);
    check("done_held_valid", dump_valid, 0);

    // Random program with load gaps, timeout exit, random dump back-pressure.
    do_reset();
    check_reset("rst1");
    ld_q.delete();
    repeat ($urandom_range(3, 8)) ld_q.push_back(($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
    load_queue(1'b1, 1'b1);
    run_core(0, 1'b0);
    dump_all(1'b1, -1);

    // Fill to the top of memory, extra word offered, simultaneous exit, reset mid-dump.
    do_reset();
    check_reset("rst2");
    ld_q.delete();
    repeat (WORDS - LOAD_BASE / 4) ld_q.push_back(($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
    load_queue(1'b0, 1'b0);
    run_core(TIMEOUT + 1, 1'b1);
    dump_all(1'b1, 3);
    check("mid_dout_valid", dump_valid, 1);
    rst = 1'b1;
    ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("rst_mid_dout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_host_port.md
Name: mem_host_port

Overview:
- Synthesizable host-side controller that owns memory port A of Mem4K.
- Three phases:
  - Load: writes a program word stream into memory while holding the core in reset.
  - Run: releases the core and passes its instruction fetches through port A.
  - Dump: when the core halts or times out, reads back the whole memory and streams it out with a non-zero marker.
- Sits between an external host link and the Mem4K / MicroarchiSC pair.

Parameters:
- LOAD_BASE, 2048: byte address of the first loaded word; multiple of 4.
- MEM_BYTES, 4096: memory size in bytes; multiple of 4.
- TIMEOUT, 4096: run-phase cycle limit.
- RD_LAT, 1: cycles from mem_abus to valid mem_dbusr; legal values 0 or 1.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- ld_valid  in  1  load word valid.
- ld_data  in  32  load word.
- ld_last  in  1  marks the final load word.
- ld_ready  out  1  load word accepted when ld_valid&ld_ready.
- core_rst  out  1  reset to the core, active-high.
- core_iaddr  in  32  core instruction address.
- core_instr  out  32  instruction data returned to the core.
- mem_enwr  out  1  port A write enable, using MM_ENB_W / MM_ENB_R encoding.
- mem_abus  out  32  port A byte address.
- mem_dbusw  out  32  port A write data.
- mem_dbusr  in  32  port A read data.
- dump_valid  out  1  dump word valid.
- dump_addr  out  32  byte address of the dump word.
- dump_data  out  32  dump word.
- dump_nz  out  1  dump_data != 0.
- dump_last  out  1  word at MEM_BYTES-4.
- dump_ready  in  1  dump word consumed when dump_valid&dump_ready.
- timed_out  out  1  run ended on timeout.
- done  out  1  dump complete.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: state=LOAD, waddr=LOAD_BASE, core_rst=1, ld_ready=1, mem_enwr=MM_ENB_R, dump_valid=0, dump_last=0, timed_out=0, done=0, cycle count=0.
- States: LOAD -> RUN -> DRD -> DOUT -> DONE.
- LOAD:
  - ld_ready=1.
  - mem_enwr=MM_ENB_W combinationally when ld_valid, with mem_abus=waddr and mem_dbusw=ld_data; the write occurs on that edge.
  - On each accept, waddr+=4.
  - Go to RUN after accepting a word with ld_last=1, or the word at MEM_BYTES-4 (no wrap; further words are never accepted).
  - core_rst is held at 1.
- RUN:
  - core_rst=0 from the first RUN cycle; ld_ready=0.
  - mem_enwr=MM_ENB_R, mem_abus=core_iaddr, core_instr=mem_dbusr.
  - The cycle count increments every cycle.
  - Halt: core_iaddr==0, or count > TIMEOUT.
  - On halt, the next cycle has core_rst=1, raddr=0, state=DRD.
  - timed_out=1 only if the exit was by count and core_iaddr!=0. A simultaneous zero-PC exit reports timed_out=0.
- DRD: mem_abus=raddr, read enable; wait RD_LAT cycles (0 means same cycle), then capture mem_dbusr into dump_data and go to DOUT.
- DOUT:
  - dump_valid=1; dump_addr, dump_data, dump_nz and dump_last are stable until accepted.
  - On dump_ready: if raddr==MEM_BYTES-4, go to DONE; else raddr+=4 and return to DRD.
- DONE: done=1, core_rst=1, dump_valid=0; held until rst.
- Outside LOAD, core_instr=mem_dbusr and mem_dbusw=0.
- Back-pressure: dump_ready=0 holds DOUT indefinitely with no loss.
- Reset mid-operation: rst in any state returns to reset values next edge. Memory contents are untouched; a partial load stays in memory.
- Address arithmetic is 32-bit; addresses are always word-aligned.

Optional Feature:
- Macro: DUMP_SKIPZERO_EN.
- Defined: in DOUT, words with dump_data==0 are not presented (dump_valid stays 0) and the FSM advances straight to the next DRD. The word at MEM_BYTES-4 is always presented with dump_last=1, even if zero.
- Undefined: every word 0..MEM_BYTES-4 is presented in order.

Test Plan:
- Load 3 words 0x00000013, 0x00100093, 0x00000067 (last) -> writes at 0x800, 0x804, 0x808; ld_ready falls; core_rst=0 on the next cycle.
- RUN with core_iaddr driven 0x800, 0x804, then 0x0 -> core_rst=1 next cycle; timed_out=0; dump starts at dump_addr=0.
- RUN with core_iaddr held 0x800, TIMEOUT=16 -> exit after count 17; timed_out=1.
- Full dump with dump_ready=1 -> 1024 words, addr 0x000..0xFFC in order; dump_nz=1 exactly at 0x800..0x808; dump_last only at 0xFFC; then done=1.
- dump_ready toggled 0/1 randomly -> identical word sequence; outputs stable while stalled.
- Load 513 words from 0x800 without ld_last -> the 512th word (0xFFC) triggers RUN; the 513th is never accepted; rst mid-DOUT -> state LOAD, waddr=0x800, core_rst=1, done=0.
